// File: rtl/uart_tx_fifo_drain_if.sv
// Read-port handshake between an async FIFO (first-word-fall-through) and the UART drain.
// The FIFO side presents empty/data; the drain side returns a one-cycle read-increment pulse per pop.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_W = 8
);
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_data;
  logic              o_fifo_rinc;

  modport master (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_rinc
  );

  modport slave (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_rinc
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a FWFT FIFO read port: pops a word whenever the FIFO is non-empty
// and serialises it as start, LSB-first data, optional parity and stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_W    = 8,
  parameter int PRESC_W   = 6,
  parameter int STOP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  uart_tx_fifo_drain_if.slave fifo,
  input  logic               i_par_en,
  input  logic               i_par_typ,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_tx,
  output logic               o_busy
);

  localparam int IDX_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic               pop;
  logic               bit_end;
  logic               last_data;
  logic               last_stop;

  // Even parity is the XOR of the word; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic [PRESC_W-1:0] clamp_presc(input logic [PRESC_W-1:0] p);
    return (p == '0) ? PRESC_W'(1) : p;
  endfunction

  assign bit_end   = (cnt_q == (presc_q - PRESC_W'(1)));
  assign last_data = (idx_q == IDX_W'(DATA_W - 1));
  assign last_stop = (idx_q == IDX_W'(STOP_BITS - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    presc_d   = presc_q;
    cnt_d     = bit_end ? '0 : cnt_q + PRESC_W'(1);
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (!fifo.i_fifo_empty) begin
          pop = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end

      // The shift register keeps the bit on the line at index 0; it shifts as each bit ends.
      S_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            if (!fifo.i_fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    // A pop captures the word and the line configuration for the whole frame.
    if (pop) begin
      state_d   = S_START;
      shreg_d   = fifo.i_fifo_data;
      par_en_d  = i_par_en;
      par_bit_d = parity_bit(fifo.i_fifo_data, i_par_typ);
      presc_d   = clamp_presc(i_prescale);
      cnt_d     = '0;
      idx_d     = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // The strobe is combinational, so it must be masked while reset holds the FSM in IDLE.
  assign fifo.o_fifo_rinc = pop & i_rstn;
  assign o_tx             = tx_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: one-stop-bit instance (dut1) and two-stop-bit instance (dut2),
// each fed by a small FWFT FIFO model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx1, busy1, tx2, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain_if #(.DATA_W(8)) fif1 ();
  uart_tx_fifo_drain_if #(.DATA_W(8)) fif2 ();

  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  logic [3:0] wr1 = 4'd0;
  logic [3:0] wr2 = 4'd0;
  logic [3:0] rd1 = 4'd0;
  logic [3:0] rd2 = 4'd0;
  int         pops1 = 0;
  int         pops2 = 0;

  assign fif1.i_fifo_empty = (wr1 == rd1);
  assign fif1.i_fifo_data  = mem1[rd1];
  assign fif2.i_fifo_empty = (wr2 == rd2);
  assign fif2.i_fifo_data  = mem2[rd2];

  always @(posedge clk) begin
    if (fif1.o_fifo_rinc) begin
      rd1   <= rd1 + 4'd1;
      pops1 <= pops1 + 1;
    end
    if (fif2.o_fifo_rinc) begin
      rd2   <= rd2 + 4'd1;
      pops2 <= pops2 + 1;
    end
  end

  uart_tx_fifo_drain #(.DATA_W(8), .PRESC_W(6), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rstn(rst_n), .fifo(fif1),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_prescale(prescale),
    .o_tx(tx1), .o_busy(busy1)
  );

  uart_tx_fifo_drain #(.DATA_W(8), .PRESC_W(6), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rstn(rst_n), .fifo(fif2),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_prescale(prescale),
    .o_tx(tx2), .o_busy(busy2)
  );

  logic s_tx1 [0:255];
  logic s_busy1 [0:255];
  logic s_rinc1 [0:255];
  logic s_tx2 [0:255];
  logic s_busy2 [0:255];

  task automatic push1(input logic [7:0] b);
    mem1[wr1] = b;
    wr1 = wr1 + 4'd1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wr2] = b;
    wr2 = wr2 + 4'd1;
  endtask

  // Sample k holds the outputs during clock k after the pop edge.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_tx1[k]   = tx1;
      s_busy1[k] = busy1;
      s_rinc1[k] = fif1.o_fifo_rinc;
      s_tx2[k]   = tx2;
      s_busy2[k] = busy2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd4;
    repeat (3) @(negedge clk);
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL rst_tx1 got=%b exp=1", tx1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy1 got=%b exp=0", busy1); end
    checks++; if (fif1.o_fifo_rinc !== 1'b0) begin failures++; $display("FAIL rst_rinc1 got=%b exp=0", fif1.o_fifo_rinc); end
    checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL rst_tx2 got=%b exp=1", tx2); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rst_busy2 got=%b exp=0", busy2); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL idle_after_rst got tx=%b busy=%b exp tx=1 busy=0", tx1, busy1); end
    checks++; if (pops1 !== 0) begin failures++; $display("FAIL idle_no_pop got=%0d exp=0", pops1); end
  endtask

  task automatic test_single_byte();
    logic [0:9] e;
    int p0;
    e = 10'b0101001011;
    @(negedge clk);
    prescale = 6'd4; par_en = 1'b0; par_typ = 1'b0;
    p0 = pops1;
    push1(8'hA5);
    #1;
    checks++; if (fif1.o_fifo_rinc !== 1'b1) begin failures++; $display("FAIL t1_rinc_idle got=%b exp=1", fif1.o_fifo_rinc); end
    capture(44);
    for (int k = 0; k < 40; k++) begin
      checks++; if (s_tx1[k] !== e[k/4]) begin failures++; $display("FAIL t1_tx k=%0d got=%b exp=%b", k, s_tx1[k], e[k/4]); end
      checks++; if (s_busy1[k] !== 1'b1) begin failures++; $display("FAIL t1_busy k=%0d got=%b exp=1", k, s_busy1[k]); end
      checks++; if (s_rinc1[k] !== 1'b0) begin failures++; $display("FAIL t1_rinc k=%0d got=%b exp=0", k, s_rinc1[k]); end
    end
    for (int k = 40; k < 44; k++) begin
      checks++; if (s_tx1[k] !== 1'b1 || s_busy1[k] !== 1'b0) begin failures++; $display("FAIL t1_idle k=%0d got tx=%b busy=%b exp tx=1 busy=0", k, s_tx1[k], s_busy1[k]); end
    end
    checks++; if (pops1 - p0 !== 1) begin failures++; $display("FAIL t1_pops got=%0d exp=1", pops1 - p0); end
  endtask

  task automatic test_parity();
    logic [0:10] e;
    for (int t = 0; t < 2; t++) begin
      e = (t == 0) ? 11'b01110000011 : 11'b01110000001;
      @(negedge clk);
      prescale = 6'd2; par_en = 1'b1; par_typ = (t == 1);
      push1(8'h07);
      #1;
      capture(24);
      for (int k = 0; k < 22; k++) begin
        checks++; if (s_tx1[k] !== e[k/2]) begin failures++; $display("FAIL t2_tx odd=%0d k=%0d got=%b exp=%b", t, k, s_tx1[k], e[k/2]); end
        checks++; if (s_busy1[k] !== 1'b1) begin failures++; $display("FAIL t2_busy odd=%0d k=%0d got=%b exp=1", t, k, s_busy1[k]); end
      end
      checks++; if (s_tx1[18] !== (t == 0)) begin failures++; $display("FAIL t2_parity odd=%0d got=%b exp=%b", t, s_tx1[18], (t == 0)); end
      checks++; if (s_busy1[22] !== 1'b0 || s_tx1[22] !== 1'b1) begin failures++; $display("FAIL t2_end odd=%0d got tx=%b busy=%b exp tx=1 busy=0", t, s_tx1[22], s_busy1[22]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp3 [0:2];
    logic [7:0] got;
    int p0;
    exp3[0] = 8'h55; exp3[1] = 8'h0F; exp3[2] = 8'hFF;
    @(negedge clk);
    prescale = 6'd1; par_en = 1'b0; par_typ = 1'b0;
    p0 = pops1;
    push1(8'h55); push1(8'h0F); push1(8'hFF);
    #1;
    checks++; if (fif1.o_fifo_rinc !== 1'b1) begin failures++; $display("FAIL t3_rinc_first got=%b exp=1", fif1.o_fifo_rinc); end
    capture(33);
    for (int k = 0; k < 33; k++) begin
      checks++; if (s_rinc1[k] !== (k == 9 || k == 19)) begin failures++; $display("FAIL t3_rinc k=%0d got=%b exp=%b", k, s_rinc1[k], (k == 9 || k == 19)); end
      checks++; if (s_busy1[k] !== (k < 30)) begin failures++; $display("FAIL t3_busy k=%0d got=%b exp=%b", k, s_busy1[k], (k < 30)); end
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) got[i] = s_tx1[10*f + 1 + i];
      checks++; if (s_tx1[10*f] !== 1'b0 || s_tx1[10*f + 9] !== 1'b1) begin failures++; $display("FAIL t3_framing f=%0d got start=%b stop=%b exp start=0 stop=1", f, s_tx1[10*f], s_tx1[10*f + 9]); end
      checks++; if (got !== exp3[f]) begin failures++; $display("FAIL t3_decode f=%0d got=%h exp=%h", f, got, exp3[f]); end
    end
    checks++; if (pops1 - p0 !== 3) begin failures++; $display("FAIL t3_pops got=%0d exp=3", pops1 - p0); end
  endtask

  task automatic test_presc0_stop2();
    logic [0:10] e;
    int p0;
    e = 11'b00000000011;
    @(negedge clk);
    prescale = 6'd0; par_en = 1'b0; par_typ = 1'b0;
    p0 = pops2;
    push2(8'h00);
    #1;
    checks++; if (fif2.o_fifo_rinc !== 1'b1) begin failures++; $display("FAIL t4_rinc got=%b exp=1", fif2.o_fifo_rinc); end
    capture(14);
    for (int k = 0; k < 11; k++) begin
      checks++; if (s_tx2[k] !== e[k] || s_busy2[k] !== 1'b1) begin failures++; $display("FAIL t4_bit k=%0d got tx=%b busy=%b exp tx=%b busy=1", k, s_tx2[k], s_busy2[k], e[k]); end
    end
    for (int k = 11; k < 14; k++) begin
      checks++; if (s_tx2[k] !== 1'b1 || s_busy2[k] !== 1'b0) begin failures++; $display("FAIL t4_idle k=%0d got tx=%b busy=%b exp tx=1 busy=0", k, s_tx2[k], s_busy2[k]); end
    end
    checks++; if (pops2 - p0 !== 1) begin failures++; $display("FAIL t4_pops got=%0d exp=1", pops2 - p0); end
  endtask

  task automatic test_config_change();
    logic [0:9]  e1;
    logic [0:10] e2;
    logic        ex;
    int p0;
    e1 = 10'b0001111001;
    e2 = 11'b01000000011;
    @(negedge clk);
    prescale = 6'd3; par_en = 1'b0; par_typ = 1'b0;
    p0 = pops1;
    push1(8'h3C);
    #1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      s_tx1[k] = tx1; s_busy1[k] = busy1; s_rinc1[k] = fif1.o_fifo_rinc;
      if (k == 6) begin
        prescale = 6'd8; par_en = 1'b1;
        push1(8'h01);
      end
    end
    for (int k = 0; k < 120; k++) begin
      ex = (k < 30) ? e1[k/3] : (k < 118) ? e2[(k-30)/8] : 1'b1;
      checks++; if (s_tx1[k] !== ex) begin failures++; $display("FAIL t5_tx k=%0d got=%b exp=%b", k, s_tx1[k], ex); end
      checks++; if (s_busy1[k] !== (k < 118)) begin failures++; $display("FAIL t5_busy k=%0d got=%b exp=%b", k, s_busy1[k], (k < 118)); end
      checks++; if (s_rinc1[k] !== (k == 29)) begin failures++; $display("FAIL t5_rinc k=%0d got=%b exp=%b", k, s_rinc1[k], (k == 29)); end
    end
    checks++; if (pops1 - p0 !== 2) begin failures++; $display("FAIL t5_pops got=%0d exp=2", pops1 - p0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:9] e;
    int p0;
    e = 10'b0100000011;
    @(negedge clk);
    prescale = 6'd2; par_en = 1'b0; par_typ = 1'b0;
    push1(8'hC3);
    #1;
    capture(11);
    checks++; if (s_tx1[10] !== 1'b0 || s_busy1[10] !== 1'b1) begin failures++; $display("FAIL t6_pre got tx=%b busy=%b exp tx=0 busy=1", s_tx1[10], s_busy1[10]); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0 || fif1.o_fifo_rinc !== 1'b0) begin failures++; $display("FAIL t6_abort got tx=%b busy=%b rinc=%b exp tx=1 busy=0 rinc=0", tx1, busy1, fif1.o_fifo_rinc); end
    push1(8'h81);
    #1;
    checks++; if (fif1.o_fifo_rinc !== 1'b0) begin failures++; $display("FAIL t6_rinc_in_rst got=%b exp=0", fif1.o_fifo_rinc); end
    p0 = pops1;
    repeat (3) @(negedge clk);
    checks++; if (pops1 !== p0 || tx1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL t6_hold got pops=%0d tx=%b busy=%b exp pops=%0d tx=1 busy=0", pops1, tx1, busy1, p0); end
    rst_n = 1'b1;
    #1;
    checks++; if (fif1.o_fifo_rinc !== 1'b1) begin failures++; $display("FAIL t6_rinc_release got=%b exp=1", fif1.o_fifo_rinc); end
    capture(22);
    for (int k = 0; k < 20; k++) begin
      checks++; if (s_tx1[k] !== e[k/2] || s_busy1[k] !== 1'b1 || s_rinc1[k] !== 1'b0) begin failures++; $display("FAIL t6_frame k=%0d got tx=%b busy=%b rinc=%b exp tx=%b busy=1 rinc=0", k, s_tx1[k], s_busy1[k], s_rinc1[k], e[k/2]); end
    end
    checks++; if (s_tx1[20] !== 1'b1 || s_busy1[20] !== 1'b0) begin failures++; $display("FAIL t6_end got tx=%b busy=%b exp tx=1 busy=0", s_tx1[20], s_busy1[20]); end
    checks++; if (pops1 - p0 !== 1) begin failures++; $display("FAIL t6_pops got=%0d exp=1", pops1 - p0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_presc0_stop2();
    test_config_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART transmitter that sits directly downstream of the async FIFO read port and runs in the read clock domain.
- Pops one word whenever the FIFO is non-empty and serialises it as a UART frame: start, data LSB-first, optional parity, stop.
- Drives the FIFO read-increment strobe, so the FIFO drains at the line rate.

Parameters:
- DATA_W, 8, data bits per frame and width of the FIFO read data.
- PRESC_W, 6, width of the clocks-per-bit prescale input.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- i_clk  in  1  operating clock (FIFO read-domain clock)
- i_rstn  in  1  active-low reset
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_data  in  DATA_W  FIFO read data; first-word-fall-through, valid while i_fifo_empty=0
- o_fifo_rinc  out  1  FIFO read-increment strobe; one-cycle pulse per pop
- i_par_en  in  1  1 = parity bit present
- i_par_typ  in  1  0 = even parity, 1 = odd parity
- i_prescale  in  PRESC_W  clocks per bit; value 0 is treated as 1
- o_tx  out  1  serial line, idle high
- o_busy  out  1  high while a frame is in progress

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rstn is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - o_tx=1, o_busy=0, state=IDLE, all counters 0.
  - o_fifo_rinc forced 0 while i_rstn=0.
  - Reset mid-frame aborts the frame immediately: o_tx returns high; the popped word is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_fifo_rinc = !i_fifo_empty (combinational).
  - On the edge where o_fifo_rinc=1: capture i_fifo_data into the shift register; capture i_par_en, i_par_typ and i_prescale (0→1) into frame-config registers; go to START.
  - Configuration changes mid-frame have no effect.
- Bit timing:
  - o_tx and o_busy are registered.
  - o_tx goes low on the clock after the pop edge.
  - Every bit lasts exactly P clocks, where P is the captured prescale.
  - A bit counter from 0 to P-1 advances the bit on reaching P-1.
- START: o_tx=0 for P clocks, then go to DATA.
- DATA:
  - Transmit DATA_W bits LSB first, one per P clocks.
  - A bit index counter of width ceil(log2(DATA_W))+1 reaches DATA_W-1, then go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Bit = XOR of the captured data when even; XNOR when odd.
  - Lasts P clocks, then go to STOP.
- STOP: o_tx=1 for STOP_BITS*P clocks.
- Frame end, in the last STOP clock:
  - If i_fifo_empty=0: o_fifo_rinc=1, capture the next word and config, go to START. This gives back-to-back frames with no gap.
  - Otherwise go to IDLE.
- o_fifo_rinc is asserted only in IDLE or the last STOP clock, and only when i_fifo_empty=0. It is never high for two consecutive cycles unless a frame of length 1 is impossible (minimum frame is 3 clocks, so never).
- o_busy=1 from the clock after the pop through the last STOP clock. It stays 1 across back-to-back frames.
- Frame length in clocks = P*(1 + DATA_W + par_en + STOP_BITS).
- Empty toggling mid-frame is ignored. i_fifo_data is sampled only on pop edges.

Test Plan:
1. Single byte, DATA_W=8, prescale=4, parity off; push 0xA5.
   - Exactly one o_fifo_rinc pulse.
   - o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 clocks total).
   - o_busy high for exactly 40 clocks; then IDLE with o_tx=1.
2. Parity even then odd, prescale=2, data 0x07 (three ones).
   - Even parity bit = 1, odd parity bit = 0.
   - Frame is 22 clocks.
3. Back-to-back, FIFO preloaded with 0x55, 0x0F, 0xFF; prescale=1.
   - Three rinc pulses spaced exactly 10 clocks apart.
   - o_busy continuously high for 30 clocks.
   - Serial stream decodes to 0x55, 0x0F, 0xFF in order.
4. Prescale 0 and STOP_BITS=2, data 0x00.
   - Each bit lasts 1 clock.
   - Stop high for 2 clocks.
   - Frame is 11 clocks.
5. Config change mid-frame: start 0x3C with prescale=3, switch i_prescale to 8 and i_par_en to 1 during DATA.
   - Current frame stays 3 clocks/bit with no parity.
   - The next frame uses 8 clocks/bit with parity.
6. Reset during DATA bit 4 of 0xC3.
   - o_tx=1, o_busy=0 and o_fifo_rinc=0 immediately.
   - After release, with the FIFO holding 0x81, a single pop occurs and a clean 0x81 frame is sent.
